brush_painter: RTL and testbench

Avalon-MM master that applies cursor brush strokes to the packed cell screen buffer in SDRAM, one accepted command at a time. It sits directly upstream of the VGA render stage. It paints a clipped square of cells around (x, y) with one cell type, using read-modify-write of 16-bit words. The renderer then scans out the updated buffer from the same `screen_ptr` base.

---
 rtl/brush_painter.sv | 222 ++++++++++++++++++++++
 tb/tb_brush_painter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brush_painter.sv
// rtl/brush_painter.sv - clipped square brush painter, 16-bit RMW over Avalon-MM.
// Optional feature macro: BRUSH_WALL_PROTECT_EN (walls survive unless erasing).
module brush_painter #(
  parameter int COLS          = 640,
  parameter int ROWS          = 480,
  parameter int WORDS_PER_ROW = COLS / 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] screen_ptr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x,
  input  logic [8:0]  cmd_y,
  input  logic [1:0]  cmd_t,
  input  logic [1:0]  cmd_radius,
  output logic        busy,
  output logic        done,
  output logic [23:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic        mem_readdatavalid,
  input  logic [15:0] mem_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD_REQ, S_RD_WAIT, S_MODIFY, S_WR_REQ, S_NEXT
  } state_t;

  localparam logic signed [10:0] COL_MAX    = 11'(COLS - 1);
  localparam logic signed [10:0] ROW_MAX    = 11'(ROWS - 1);
  localparam logic [23:0]        ROW_STRIDE = 24'(WORDS_PER_ROW);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  t_q, t_d;
  logic [1:0]  r_q, r_d;
  logic [10:0] x0_q, x0_d;
  logic [10:0] x1_q, x1_d;
  logic [10:0] y1_q, y1_d;
  logic [10:0] row_q, row_d;
  logic [7:0]  word_q, word_d;
  logic [23:0] row_base_q, row_base_d;
  logic [23:0] addr_q, addr_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        skip_q, skip_d;

  logic signed [10:0] xs_lo, xs_hi, ys_lo, ys_hi;
  logic [10:0]        clip_x0, clip_x1, clip_y0, clip_y1;
  logic [23:0]        first_base;
  logic               out_of_range;
  logic [15:0]        mod_data;
  logic [10:0]        col;
  logic               unused_ptr_hi;

  assign unused_ptr_hi = ^screen_ptr[31:24];

  // Clip arithmetic is signed so x-r / y-r may go negative before clamping.
  assign xs_lo = $signed({1'b0, x_q}) - $signed({9'b0, r_q});
  assign xs_hi = $signed({1'b0, x_q}) + $signed({9'b0, r_q});
  assign ys_lo = $signed({2'b0, y_q}) - $signed({9'b0, r_q});
  assign ys_hi = $signed({2'b0, y_q}) + $signed({9'b0, r_q});

  assign clip_x0 = xs_lo[10] ? 11'd0 : xs_lo;
  assign clip_x1 = (xs_hi > COL_MAX) ? COL_MAX : xs_hi;
  assign clip_y0 = ys_lo[10] ? 11'd0 : ys_lo;
  assign clip_y1 = (ys_hi > ROW_MAX) ? ROW_MAX : ys_hi;

  assign out_of_range = ({1'b0, x_q} > $unsigned(COL_MAX)) ||
                        ({2'b0, y_q} > $unsigned(ROW_MAX));
  assign first_base   = screen_ptr[23:0] + 24'(clip_y0) * ROW_STRIDE;

  always_comb begin
    mod_data = rdata_q;
    col      = '0;
    for (int k = 0; k < 8; k++) begin
      col = {word_q, 3'(k)};
      if (col >= x0_q && col <= x1_q) begin
`ifdef BRUSH_WALL_PROTECT_EN
        if (!(rdata_q[2*k +: 2] == 2'd3 && t_q != 2'd0)) begin
          mod_data[2*k +: 2] = t_q;
        end
`else
        mod_data[2*k +: 2] = t_q;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    t_d        = t_q;
    r_d        = r_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    row_d      = row_q;
    word_d     = word_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    skip_d     = skip_q;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          t_d     = cmd_t;
          r_d     = cmd_radius;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x0_d   = clip_x0;
        x1_d   = clip_x1;
        y1_d   = clip_y1;
        row_d  = clip_y0;
        skip_d = out_of_range;
        if (out_of_range) begin
          state_d = S_NEXT;
        end else begin
          row_base_d = first_base;
          word_d     = 8'(clip_x0 >> 3);
          addr_d     = first_base + 24'(clip_x0 >> 3);
          state_d    = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!mem_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_readdatavalid) begin
          rdata_d = mem_readdata;
          state_d = S_MODIFY;
        end
      end
      S_MODIFY: begin
        wdata_d = mod_data;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (!mem_waitrequest) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (!skip_q && word_q < 8'(x1_q >> 3)) begin
          word_d  = word_q + 8'd1;
          addr_d  = addr_q + 24'd1;
          state_d = S_RD_REQ;
        end else if (!skip_q && row_q < y1_q) begin
          row_d      = row_q + 11'd1;
          row_base_d = row_base_q + ROW_STRIDE;
          word_d     = 8'(x0_q >> 3);
          addr_d     = row_base_q + ROW_STRIDE + 24'(x0_q >> 3);
          state_d    = S_RD_REQ;
        end else begin
          done    = 1'b1;
          skip_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      t_q        <= '0;
      r_q        <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      row_q      <= '0;
      word_q     <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      t_q        <= t_d;
      r_q        <= r_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      row_q      <= row_d;
      word_q     <= word_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      skip_q     <= skip_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = busy_q;
  assign mem_read      = (state_q == S_RD_REQ);
  assign mem_write     = (state_q == S_WR_REQ);
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;

endmodule

// File: tb/tb_brush_painter.sv
// tb/tb_brush_painter.sv - directed bench for brush_painter with an Avalon slave model.
// Wall expectations follow BRUSH_WALL_PROTECT_EN.
module tb_brush_painter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] screen_ptr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x;
  logic [8:0]  cmd_y;
  logic [1:0]  cmd_t;
  logic [1:0]  cmd_radius;
  logic        busy;
  logic        done;
  logic [23:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_writedata;
  logic        mem_waitrequest   = 1'b0;
  logic        mem_readdatavalid = 1'b0;
  logic [15:0] mem_readdata      = 16'h0000;

  brush_painter dut (
    .clock(clock), .reset(reset), .screen_ptr(screen_ptr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_t(cmd_t), .cmd_radius(cmd_radius), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
    .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:8191];
  logic [23:0] rd_log [$];
  logic [23:0] wa_log [$];
  logic [15:0] wd_log [$];
  int          stall_cfg  = 0;
  bit          inject_rdv = 0;

  int          stab_bad   = 0;
  int          rw_both    = 0;
  int          stall_seen = 0;
  int          stall_cnt  = 0;
  bit          rd_pending = 0;
  logic [23:0] rd_addr_l  = '0;
  logic [23:0] hold_a     = '0;
  logic [15:0] hold_d     = '0;
  logic [1:0]  hold_rw    = '0;

  int errors = 0;
  int checks = 0;
  int rd_base, wr_base, cyc, ndone, seen0, found;

  // Slave acts at negedge: decisions made here are sampled by the DUT at the next posedge.
  always @(negedge clock) begin
    mem_readdatavalid = 1'b0;
    mem_readdata      = 16'h0000;
    if (rd_pending) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = mem[rd_addr_l[12:0]];
    end
    rd_pending = 1'b0;
    if (inject_rdv && mem_write) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = 16'hDEAD;
    end
    if (mem_read && mem_write) rw_both++;
    if (reset || !(mem_read || mem_write)) begin
      stall_cnt       = 0;
      mem_waitrequest = 1'b0;
    end else begin
      if (stall_cnt == 0) begin
        hold_a  = mem_address;
        hold_d  = mem_writedata;
        hold_rw = {mem_read, mem_write};
      end else if (mem_address != hold_a || mem_writedata != hold_d ||
                   {mem_read, mem_write} != hold_rw) begin
        stab_bad++;
      end
      if (stall_cnt < stall_cfg) begin
        mem_waitrequest = 1'b1;
        stall_cnt++;
        stall_seen++;
      end else begin
        mem_waitrequest = 1'b0;
        stall_cnt       = 0;
        if (mem_read) begin
          rd_log.push_back(mem_address);
          rd_pending = 1'b1;
          rd_addr_l  = mem_address;
        end else begin
          wa_log.push_back(mem_address);
          wd_log.push_back(mem_writedata);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wa_at(input int i);
    if (wr_base + i < wa_log.size()) return 32'(wa_log[wr_base + i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    if (wr_base + i < wd_log.size()) return 32'(wd_log[wr_base + i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd_at(input int i);
    if (rd_base + i < rd_log.size()) return 32'(rd_log[rd_base + i]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic run_cmd(input logic [31:0] ptr, input int x, input int y, input int t,
                         input int r, input bit hold);
    rd_base    = rd_log.size();
    wr_base    = wa_log.size();
    screen_ptr = ptr;
    @(negedge clock);
    cmd_x      = 10'(x);
    cmd_y      = 9'(y);
    cmd_t      = 2'(t);
    cmd_radius = 2'(r);
    cmd_valid  = 1'b1;
    @(negedge clock);
    if (!hold) cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    cyc   = 0;
    ndone = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc++;
      if (done) begin
        ndone++;
        break;
      end
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    check("done_seen", 32'(ndone), 32'd1);
    @(negedge clock);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(cmd_ready), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  function automatic int wr_n();
    return wa_log.size() - wr_base;
  endfunction

  function automatic int rd_n();
    return rd_log.size() - rd_base;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    reset      = 1'b1;
    screen_ptr = 32'h0;
    cmd_valid  = 1'b0;
    cmd_x      = '0;
    cmd_y      = '0;
    cmd_t      = '0;
    cmd_radius = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_writedata", 32'(mem_writedata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single cell: col 9 -> word 0x1001, cell k=1 -> bits [3:2]
    mem[13'h1001] = 16'h0000;
    run_cmd(32'h1000, 9, 0, 1, 0, 1'b0);
    check("single_rd_n", 32'(rd_n()), 32'd1);
    check("single_rd_addr", rd_at(0), 32'h1001);
    check("single_wr_n", 32'(wr_n()), 32'd1);
    check("single_wr_addr", wa_at(0), 32'h1001);
    check("single_wr_data", wd_at(0), 32'h0004);
    check("single_cycles", 32'(cyc), 32'd6);

    // Top-left clip: rows 0..3, cells 0..3 of word 0 in each row
    run_cmd(32'h0, 0, 0, 2, 3, 1'b0);
    check("clip_wr_n", 32'(wr_n()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("clip_wr_addr", wa_at(i), 32'(i * 80));
      check("clip_wr_data", wd_at(i), 32'h00AA);
    end
    check("clip_cycles", 32'(cyc), 32'd21);

    // Word straddle, cmd_valid held through the command to prove no re-accept
    for (int i = 0; i < 300; i++) mem[i] = 16'h5555;
    run_cmd(32'h0, 8, 1, 3, 1, 1'b1);
    check("strad_wr_n", 32'(wr_n()), 32'd6);
    check("strad_rd_n", 32'(rd_n()), 32'd6);
    check("strad_r0_addr", wa_at(0), 32'd0);
    check("strad_r0_data", wd_at(0), 32'hD555);
    check("strad_r1a_addr", wa_at(2), 32'd80);
    check("strad_r1a_data", wd_at(2), 32'hD555);
    check("strad_r1b_addr", wa_at(3), 32'd81);
    check("strad_r1b_data", wd_at(3), 32'h555F);
    check("strad_r2b_addr", wa_at(5), 32'd161);
    check("strad_cycles", 32'(cyc), 32'd31);

    // Stalls of 5 cycles on read and write, stray readdatavalid during write
    mem[402]   = 16'hFFFF;
    stall_cfg  = 5;
    inject_rdv = 1'b1;
    seen0      = stall_seen;
    run_cmd(32'h0, 20, 5, 2, 0, 1'b0);
    stall_cfg  = 0;
    inject_rdv = 1'b0;
    check("stall_rd_n", 32'(rd_n()), 32'd1);
    check("stall_wr_n", 32'(wr_n()), 32'd1);
    check("stall_wr_addr", wa_at(0), 32'd402);
    check("stall_wr_data", wd_at(0), 32'hFEFF);
    check("stall_cycles", 32'(cyc), 32'd16);
    check("stall_count", 32'(stall_seen - seen0), 32'd10);
    check("stall_stable", 32'(stab_bad), 32'd0);

    // Wall handling: cells 0..2 masked, cell 3 outside the brush
    mem[13'h200] = 16'h00FF;
    mem[13'h250] = 16'h00FF;
    run_cmd(32'h200, 1, 0, 1, 1, 1'b0);
    check("wall_wr_n", 32'(wr_n()), 32'd2);
`ifdef BRUSH_WALL_PROTECT_EN
    check("wall_sand_r0", wd_at(0), 32'h00FF);
    check("wall_sand_r1", wd_at(1), 32'h00FF);
`else
    check("wall_sand_r0", wd_at(0), 32'h00D5);
    check("wall_sand_r1", wd_at(1), 32'h00D5);
`endif
    run_cmd(32'h200, 1, 0, 0, 1, 1'b0);
    check("wall_erase_r0", wd_at(0), 32'h00C0);
    check("wall_erase_addr1", wa_at(1), 32'h250);

    // Out-of-range centres: done with no bus traffic
    run_cmd(32'h0, 700, 10, 1, 2, 1'b0);
    check("oob_x_rd_n", 32'(rd_n()), 32'd0);
    check("oob_x_wr_n", 32'(wr_n()), 32'd0);
    run_cmd(32'h0, 5, 480, 1, 2, 1'b0);
    check("oob_y_wr_n", 32'(rd_n() + wr_n()), 32'd0);

    // Reset while a write is stalled on the bus
    stall_cfg  = 20;
    wr_base    = wa_log.size();
    screen_ptr = 32'h1000;
    @(negedge clock);
    cmd_x      = 10'd9;
    cmd_y      = 9'd0;
    cmd_t      = 2'd1;
    cmd_radius = 2'd0;
    cmd_valid  = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 80; i++) begin
      if (mem_write) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    check("rmw_reached_write", 32'(found), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_address", 32'(mem_address), 32'd0);
    check("midrst_mem_writedata", 32'(mem_writedata), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    reset     = 1'b0;
    stall_cfg = 0;
    @(negedge clock);
    check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("postrst_done", 32'(done), 32'd0);
    check("postrst_no_write", 32'(wr_n()), 32'd0);

    check("read_write_exclusive", 32'(rw_both), 32'd0);
    check("stable_overall", 32'(stab_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
